tube_scan_ctrl: RTL and testbench
=================================

Name: tube_scan_ctrl

Overview:
- Sequential controller for the seven-segment tube display.
- Captures 32-bit IO write data when the tube is selected, holds it in a display register and time-multiplexes its eight hex nibbles onto the shared segment bus.
- Sits between the memory/IO write path and the board tube pins. Replaces a latch-based capture with a clocked register and scan sequencer.

Parameters:
- CLK_DIV, 100000: clk cycles each digit stays enabled; legal range ≥ 4.
- BLANK_CYC, 2: cycles at the end of each digit slot where all anodes are off (anti-ghosting); must be < CLK_DIV.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-high reset (asserted = 1).
- TubeCtrl_i  input  1  tube address decode select from the memory/IO decoder.
- iow_i  input  1  IO write strobe.
- iowrite_data_i  input  32  write data from the memory/IO mux.
- seg_o  output  8  active-low segments; [7]=dp, [6:0]=g..a.
- an_o  output  8  active-low digit enables; bit k = digit k, where digit 0 is the rightmost and shows nibble [3:0].
- wr_ack_o  output  1  one-cycle pulse confirming a capture.
- disp_data_o  output  32  current display register contents, for readback.

Behaviour:
- Reset (async, rst_n=1) drives the following until release:
  - disp_data_o=0, scan counter=0, digit index=0.
  - an_o=8'hFE, seg_o=8'hC0, wr_ack_o=0.
- Capture:
  - At a rising edge with TubeCtrl_i=1 and iow_i=1, disp_data_o <= iowrite_data_i.
  - wr_ack_o=1 in the following cycle only.
  - Back-to-back writes: each is captured and each produces an ack, so ack stays high.
  - A write with TubeCtrl_i=0 or iow_i=0 is ignored.
- Scan counter:
  - Counts 0..CLK_DIV-1 and wraps to 0.
  - On wrap, digit index advances 0→1→…→7→0.
- Anode output:
  - an_o = ~(1<<index) while counter < CLK_DIV-BLANK_CYC.
  - an_o = 8'hFF otherwise.
- Segment output:
  - seg_o = hex decode of nibble disp_data_o[4*index+3 : 4*index], dp always off (bit7=1).
  - Decode table 0..F: C0 F9 A4 B0 99 92 82 F8 80 90 88 83 C6 A1 86 8E.
  - an_o and seg_o are registered: they reflect counter/index/data one cycle later.
- Simultaneous capture and digit advance: both happen on the same edge. The new digit's first registered output uses the new data.
- Mid-slot capture: the current digit's segments change on the next registered update; no restart of the slot.
- Reset mid-scan: immediate return to reset values; no partial-slot memory.

Optional Feature:
- Macro: TUBE_LEADING_ZERO_BLANK_EN.
- When defined:
  - Digit k (k ≥ 1) is blanked if all nibbles k..7 are zero: an_o held 8'hFF for that slot, seg_o=8'hFF.
  - Digit 0 is always shown, so value 0 displays a single "0".
  - Slot timing is unchanged.
- When undefined: all eight digits are always driven, including leading zeros.

Test Plan (CLK_DIV=4, BLANK_CYC=1):
- Reset check: assert rst_n mid-cycle → outputs immediately read an_o=FE, seg_o=C0, disp_data_o=0, wr_ack_o=0, with no clock edge required.
- Single capture: TubeCtrl_i=1, iow_i=1, data=32'h12345678 for one cycle →
  - disp_data_o=12345678 and wr_ack_o=1 for exactly one cycle.
  - Scanning shows digit0 seg=80 ("8"), digit1 F8 ("7"), …, digit7 F9 ("1").
- Gated write: iow_i=1 with TubeCtrl_i=0, data=FFFFFFFF → disp_data_o unchanged, wr_ack_o stays 0.
- Scan timing:
  - Per 4-cycle slot: an_o is active for 3 cycles, then FF for 1 cycle.
  - Index sequence FE,FD,FB,…,7F then back to FE after 32 cycles.
  - Data ABCDEF09 gives segments 90,C0,8E,86,A1,C6,83,88.
- Boundary capture: write 0000000F on the same edge the index wraps 7→0 → the first digit0 output is 8E, with no stale value shown.
- With TUBE_LEADING_ZERO_BLANK_EN:
  - Data 00000A05: digits 3..7 have an_o=FF and seg_o=FF; digits 0..2 show 92, C0, 88.
  - Data 0: only digit0 is lit, seg=C0.

Source files
------------

// File: rtl/tube_scan_ctrl.sv
// Seven-segment tube controller: clocked capture of IO write data and an eight-digit scan sequencer.
// Optional build macro TUBE_LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module tube_scan_ctrl #(
    parameter int CLK_DIV   = 100000,
    parameter int BLANK_CYC = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        TubeCtrl_i,
    input  logic        iow_i,
    input  logic [31:0] iowrite_data_i,
    output logic [7:0]  seg_o,
    output logic [7:0]  an_o,
    output logic        wr_ack_o,
    output logic [31:0] disp_data_o
);

    // One extra bit so CLK_DIV-BLANK_CYC stays representable when BLANK_CYC is 0.
    localparam int CW = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(CLK_DIV - BLANK_CYC);

    function automatic logic [7:0] hex_decode(input logic [3:0] nib);
        logic [7:0] s;
        case (nib)
            4'h0: s = 8'hC0;  4'h1: s = 8'hF9;  4'h2: s = 8'hA4;  4'h3: s = 8'hB0;
            4'h4: s = 8'h99;  4'h5: s = 8'h92;  4'h6: s = 8'h82;  4'h7: s = 8'hF8;
            4'h8: s = 8'h80;  4'h9: s = 8'h90;  4'hA: s = 8'h88;  4'hB: s = 8'h83;
            4'hC: s = 8'hC6;  4'hD: s = 8'hA1;  4'hE: s = 8'h86;  default: s = 8'h8E;
        endcase
        return s;
    endfunction

    logic [CW-1:0] cnt_p0;
    logic [2:0]    idx_p0;
    logic [31:0]   disp_p0;
    logic          vld_p0;
    logic          wrap_p0;
    logic [3:0]    nib_p0;
    logic [7:0]    an_next;
    logic [7:0]    seg_next;
    logic          vld_p1;
    logic [7:0]    an_p1;
    logic [7:0]    seg_p1;

    always_comb begin
        vld_p0   = TubeCtrl_i & iow_i;
        wrap_p0  = (cnt_p0 == CNT_LAST);
        nib_p0   = disp_p0[{idx_p0, 2'b00} +: 4];
        an_next  = (cnt_p0 < CNT_BLANK) ? ~(8'b1 << idx_p0) : 8'hFF;
        seg_next = hex_decode(nib_p0);
`ifdef TUBE_LEADING_ZERO_BLANK_EN
        // Digit k is a leading zero when it and every nibble above it are zero.
        if ((idx_p0 != 3'd0) && ((disp_p0 >> {idx_p0, 2'b00}) == 32'd0)) begin
            an_next  = 8'hFF;
            seg_next = 8'hFF;
        end
`endif
    end

    // p0 -> p1: scan state and capture feed the registered pin drivers
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            cnt_p0  <= '0;
            idx_p0  <= 3'd0;
            disp_p0 <= 32'd0;
            vld_p1  <= 1'b0;
            an_p1   <= 8'hFE;
            seg_p1  <= 8'hC0;
        end else begin
            cnt_p0 <= wrap_p0 ? '0 : cnt_p0 + 1'b1;
            if (wrap_p0) begin
                idx_p0 <= idx_p0 + 3'd1;
            end
            if (vld_p0) begin
                disp_p0 <= iowrite_data_i;
            end
            vld_p1 <= vld_p0;
            an_p1  <= an_next;
            seg_p1 <= seg_next;
        end
    end

    assign seg_o       = seg_p1;
    assign an_o        = an_p1;
    assign wr_ack_o    = vld_p1;
    assign disp_data_o = disp_p0;

endmodule

// File: tb/tb_tube_scan_ctrl.sv
// Bench for tube_scan_ctrl with CLK_DIV=4, BLANK_CYC=1; a behavioural model queues per-cycle expectations.
module tb_tube_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        TubeCtrl_i;
    logic        iow_i;
    logic [31:0] iowrite_data_i;
    logic [7:0]  seg_o;
    logic [7:0]  an_o;
    logic        wr_ack_o;
    logic [31:0] disp_data_o;

    tube_scan_ctrl #(.CLK_DIV(4), .BLANK_CYC(1)) dut (
        .clk(clk), .rst_n(rst_n), .TubeCtrl_i(TubeCtrl_i), .iow_i(iow_i),
        .iowrite_data_i(iowrite_data_i), .seg_o(seg_o), .an_o(an_o),
        .wr_ack_o(wr_ack_o), .disp_data_o(disp_data_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  an;
        logic [7:0]  seg;
        logic [31:0] data;
        logic        ack;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    int          m_cnt;
    logic [2:0]  m_idx;
    logic [31:0] m_data;
    logic [7:0]  seen[8];

    function automatic logic [7:0] seg_of(input logic [3:0] n);
        logic [7:0] tbl[16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        return tbl[n];
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, want);
        end
    endtask

    task automatic model_reset();
        m_cnt  = 0;
        m_idx  = 3'd0;
        m_data = 32'd0;
        sb.delete();
    endtask

    // Called at a falling edge: drive inputs, push the expectation, clock once, compare.
    task automatic cycle(input logic tc, input logic iow, input logic [31:0] d);
        exp_t e;
        exp_t g;
        logic cap;
        TubeCtrl_i     = tc;
        iow_i          = iow;
        iowrite_data_i = d;
        cap   = tc & iow;
        e.an  = (m_cnt < 3) ? ~(8'b1 << m_idx) : 8'hFF;
        e.seg = seg_of(m_data[4*m_idx +: 4]);
`ifdef TUBE_LEADING_ZERO_BLANK_EN
        if (m_idx != 3'd0 && (m_data >> (4*m_idx)) == 32'd0) begin
            e.an  = 8'hFF;
            e.seg = 8'hFF;
        end
`endif
        e.data = cap ? d : m_data;
        e.ack  = cap;
        sb.push_back(e);
        m_data = e.data;
        if (m_cnt == 3) begin
            m_cnt = 0;
            m_idx = m_idx + 3'd1;
        end else begin
            m_cnt++;
        end
        @(posedge clk);
        #1;
        g = sb.pop_front();
        chk("an", {24'd0, an_o}, {24'd0, g.an});
        chk("seg", {24'd0, seg_o}, {24'd0, g.seg});
        chk("disp", disp_data_o, g.data);
        chk("ack", {31'd0, wr_ack_o}, {31'd0, g.ack});
        for (int k = 0; k < 8; k++) begin
            if (an_o == ~(8'b1 << k)) seen[k] = seg_o;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'hDEAD_BEEF);
    endtask

    task automatic clear_seen();
        for (int k = 0; k < 8; k++) seen[k] = 8'h00;
    endtask

    task automatic chk_digits(input string tag, input logic [7:0] want[8]);
        for (int k = 0; k < 8; k++) chk($sformatf("%s_d%0d", tag, k), {24'd0, seen[k]}, {24'd0, want[k]});
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_an"}, {24'd0, an_o}, 32'h0000_00FE);
        chk({tag, "_seg"}, {24'd0, seg_o}, 32'h0000_00C0);
        chk({tag, "_disp"}, disp_data_o, 32'd0);
        chk({tag, "_ack"}, {31'd0, wr_ack_o}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] w_a[8];
        logic [7:0] w_b[8];
        logic [7:0] w_c[8];
        logic [7:0] w_z[8];
        int guard;

        rst_n = 1'b1;
        TubeCtrl_i = 1'b0;
        iow_i = 1'b0;
        iowrite_data_i = 32'd0;
        repeat (2) @(negedge clk);
        chk_reset_outputs("rst");
        rst_n = 1'b0;
        model_reset();

        // single capture, then a full scan of 12345678
        cycle(1'b1, 1'b1, 32'h1234_5678);
        clear_seen();
        idle(40);
        w_a = '{8'h80, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};
        chk_digits("scan1", w_a);

        // gated writes must not capture
        cycle(1'b0, 1'b1, 32'hFFFF_FFFF);
        cycle(1'b1, 1'b0, 32'hFFFF_FFFF);
        chk("gated_disp", disp_data_o, 32'h1234_5678);

        // back-to-back writes keep ack high
        cycle(1'b1, 1'b1, 32'h0BAD_F00D);
        cycle(1'b1, 1'b1, 32'hABCD_EF09);
        chk("b2b_ack", {31'd0, wr_ack_o}, 32'd1);
        clear_seen();
        idle(40);
        w_b = '{8'h90, 8'hC0, 8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88};
        chk_digits("scan2", w_b);

        // capture on the same edge the index wraps 7 -> 0
        guard = 0;
        while (!(m_cnt == 3 && m_idx == 3'd7) && guard < 40) begin
            idle(1);
            guard++;
        end
        chk("align_guard", {31'd0, (guard < 40)}, 32'd1);
        cycle(1'b1, 1'b1, 32'h0000_000F);
        idle(1);
        chk("wrap_an", {24'd0, an_o}, 32'h0000_00FE);
        chk("wrap_seg", {24'd0, seg_o}, 32'h0000_008E);

        // leading-zero data
        cycle(1'b1, 1'b1, 32'h0000_0A05);
        clear_seen();
        idle(40);
`ifdef TUBE_LEADING_ZERO_BLANK_EN
        w_c = '{8'h92, 8'hC0, 8'h88, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
`else
        w_c = '{8'h92, 8'hC0, 8'h88, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
`endif
        chk_digits("lz", w_c);

        cycle(1'b1, 1'b1, 32'h0000_0000);
        clear_seen();
        idle(40);
`ifdef TUBE_LEADING_ZERO_BLANK_EN
        w_z = '{8'hC0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
`else
        w_z = '{8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
`endif
        chk_digits("zero", w_z);

        // asynchronous reset mid-scan, away from any clock edge
        cycle(1'b1, 1'b1, 32'h5A5A_A5A5);
        idle(5);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        chk_reset_outputs("async_rst");
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        idle(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
